// File: rtl/jelly2_necolink_aw_msg_receiver.sv
// rtl/jelly2_necolink_aw_msg_receiver.sv - reassembles NecoLink 0x10 messages into one AXI4 AW beat
// Defining JELLY2_NECOLINK_AW_RX_STATUS_EN adds saturating err_format_count/err_overflow_count outputs.
module jelly2_necolink_aw_msg_receiver #(
  parameter int AXI4_ID_WIDTH   = 6,
  parameter int AXI4_ADDR_WIDTH = 64,
  parameter int AXI4_LEN_WIDTH  = 8,
  parameter int AXI4_QOS_WIDTH  = 4
) (
  input  logic                       reset,
  input  logic                       clk,
  input  logic                       cke,
  input  logic                       s_msg_rx_first,
  input  logic                       s_msg_rx_last,
  input  logic [7:0]                 s_msg_rx_src_node,
  input  logic [7:0]                 s_msg_rx_data,
  input  logic                       s_msg_rx_valid,
  output logic [AXI4_ID_WIDTH-1:0]   m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0] m_axi4_awaddr,
  output logic [AXI4_LEN_WIDTH-1:0]  m_axi4_awlen,
  output logic [2:0]                 m_axi4_awsize,
  output logic [1:0]                 m_axi4_awburst,
  output logic                       m_axi4_awlock,
  output logic [3:0]                 m_axi4_awcache,
  output logic [2:0]                 m_axi4_awprot,
  output logic [AXI4_QOS_WIDTH-1:0]  m_axi4_awqos,
  output logic [3:0]                 m_axi4_awregion,
  output logic                       m_axi4_awvalid,
  input  logic                       m_axi4_awready,
  output logic [7:0]                 m_aw_src_node,
  output logic                       err_format,
  output logic                       err_overflow
`ifdef JELLY2_NECOLINK_AW_RX_STATUS_EN
  ,
  output logic [15:0]                err_format_count,
  output logic [15:0]                err_overflow_count
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DISCARD} state_t;

  typedef struct packed {
    logic [AXI4_ID_WIDTH-1:0]   id;
    logic [AXI4_ADDR_WIDTH-1:0] addr;
    logic [AXI4_LEN_WIDTH-1:0]  len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
    logic                       lock;
    logic [3:0]                 cache;
    logic [2:0]                 prot;
    logic [AXI4_QOS_WIDTH-1:0]  qos;
    logic [3:0]                 region;
    logic [7:0]                 src;
  } aw_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       src_q, src_d;
  logic [15:0][7:0] buf_q, buf_d;
  aw_t              aw_q, aw_d, aw_load;
  logic             awvalid_q, awvalid_d;
  logic             fmt_q, fmt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             start;
  logic             complete;
  logic [15:0]      id16;
  logic [63:0]      addr64;
  logic             unused_bits;

  assign accept = cke & s_msg_rx_valid;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    src_d    = src_q;
    buf_d    = buf_q;
    fmt_d    = 1'b0;
    start    = 1'b0;
    complete = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: start = s_msg_rx_first;
        ST_COLLECT: begin
          if (s_msg_rx_first) begin
            fmt_d = 1'b1;
            start = 1'b1;
          end else begin
            buf_d[idx_q] = s_msg_rx_data;
            if (s_msg_rx_last) begin
              state_d = ST_IDLE;
              idx_d   = 4'd0;
              if (idx_q == 4'd15) complete = 1'b1;
              else                fmt_d    = 1'b1;
            end else if (idx_q == 4'd15) begin
              fmt_d   = 1'b1;
              state_d = ST_DISCARD;
              idx_d   = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        ST_DISCARD: begin
          if (s_msg_rx_first)     start   = 1'b1;
          else if (s_msg_rx_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      // A first byte always restarts decoding, whatever state we were in.
      if (start) begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        if (s_msg_rx_data == 8'h10) begin
          if (s_msg_rx_last) begin
            fmt_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
            idx_d   = 4'd1;
            src_d   = s_msg_rx_src_node;
          end
        end else if (!s_msg_rx_last) begin
          state_d = ST_DISCARD;
        end
      end
    end
  end

  assign id16        = buf_d[2:1];
  assign addr64      = buf_d[10:3];
  assign unused_bits = ^{buf_d, id16, addr64};

  always_comb begin
    aw_load        = '0;
    aw_load.id     = id16[AXI4_ID_WIDTH-1:0];
    aw_load.addr   = addr64[AXI4_ADDR_WIDTH-1:0];
    aw_load.len    = buf_d[11][AXI4_LEN_WIDTH-1:0];
    aw_load.burst  = buf_d[12][1:0];
    aw_load.lock   = buf_d[12][2];
    aw_load.prot   = buf_d[12][6:4];
    aw_load.size   = buf_d[13][2:0];
    aw_load.cache  = buf_d[14][3:0];
    aw_load.region = buf_d[14][7:4];
    aw_load.qos    = buf_d[15][AXI4_QOS_WIDTH-1:0];
    aw_load.src    = src_q;
  end

  // The slot is free when empty or being handed off this cycle, so reloads need no bubble.
  always_comb begin
    aw_d      = aw_q;
    awvalid_d = awvalid_q & ~m_axi4_awready;
    ovf_d     = 1'b0;
    if (complete) begin
      if (!awvalid_q || m_axi4_awready) begin
        aw_d      = aw_load;
        awvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      src_q     <= 8'd0;
      buf_q     <= '0;
      aw_q      <= '0;
      awvalid_q <= 1'b0;
      fmt_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (cke) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      src_q     <= src_d;
      buf_q     <= buf_d;
      aw_q      <= aw_d;
      awvalid_q <= awvalid_d;
      fmt_q     <= fmt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_axi4_awid     = aw_q.id;
  assign m_axi4_awaddr   = aw_q.addr;
  assign m_axi4_awlen    = aw_q.len;
  assign m_axi4_awsize   = aw_q.size;
  assign m_axi4_awburst  = aw_q.burst;
  assign m_axi4_awlock   = aw_q.lock;
  assign m_axi4_awcache  = aw_q.cache;
  assign m_axi4_awprot   = aw_q.prot;
  assign m_axi4_awqos    = aw_q.qos;
  assign m_axi4_awregion = aw_q.region;
  assign m_axi4_awvalid  = awvalid_q;
  assign m_aw_src_node   = aw_q.src;
  assign err_format      = fmt_q;
  assign err_overflow    = ovf_q;

`ifdef JELLY2_NECOLINK_AW_RX_STATUS_EN
  logic [15:0] fmt_cnt_q, fmt_cnt_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    fmt_cnt_d = fmt_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (fmt_d && fmt_cnt_q != 16'hffff) fmt_cnt_d = fmt_cnt_q + 16'd1;
    if (ovf_d && ovf_cnt_q != 16'hffff) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fmt_cnt_q <= 16'd0;
      ovf_cnt_q <= 16'd0;
    end else if (cke) begin
      fmt_cnt_q <= fmt_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign err_format_count   = fmt_cnt_q;
  assign err_overflow_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_jelly2_necolink_aw_msg_receiver.sv
// tb/tb_jelly2_necolink_aw_msg_receiver.sv - scoreboard bench for the NecoLink AW message receiver
`timescale 1ns/1ps
module tb_jelly2_necolink_aw_msg_receiver;
  localparam int IDW = 6;
  localparam int AW  = 64;
  localparam int LW  = 8;
  localparam int QW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           cke;
  logic           first, last, valid;
  logic [7:0]     src, data;
  logic [IDW-1:0] awid;
  logic [AW-1:0]  awaddr;
  logic [LW-1:0]  awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awlock;
  logic [3:0]     awcache;
  logic [2:0]     awprot;
  logic [QW-1:0]  awqos;
  logic [3:0]     awregion;
  logic           awvalid;
  logic           awready;
  logic [7:0]     aw_src;
  logic           err_format, err_overflow;
`ifdef JELLY2_NECOLINK_AW_RX_STATUS_EN
  logic [15:0]    fmt_count, ovf_count;
`endif

  always #5 clk = ~clk;

  jelly2_necolink_aw_msg_receiver #(
    .AXI4_ID_WIDTH(IDW), .AXI4_ADDR_WIDTH(AW), .AXI4_LEN_WIDTH(LW), .AXI4_QOS_WIDTH(QW)
  ) dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_msg_rx_first(first), .s_msg_rx_last(last), .s_msg_rx_src_node(src),
    .s_msg_rx_data(data), .s_msg_rx_valid(valid),
    .m_axi4_awid(awid), .m_axi4_awaddr(awaddr), .m_axi4_awlen(awlen),
    .m_axi4_awsize(awsize), .m_axi4_awburst(awburst), .m_axi4_awlock(awlock),
    .m_axi4_awcache(awcache), .m_axi4_awprot(awprot), .m_axi4_awqos(awqos),
    .m_axi4_awregion(awregion), .m_axi4_awvalid(awvalid), .m_axi4_awready(awready),
    .m_aw_src_node(aw_src), .err_format(err_format), .err_overflow(err_overflow)
`ifdef JELLY2_NECOLINK_AW_RX_STATUS_EN
    , .err_format_count(fmt_count), .err_overflow_count(ovf_count)
`endif
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic           lock;
    logic [3:0]     cache;
    logic [2:0]     prot;
    logic [3:0]     region;
    logic [QW-1:0]  qos;
    logic [7:0]     src;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_exp, mon_act;
  int         n_checks = 0;
  int         n_fail = 0;
  int         fmt_seen = 0, ovf_seen = 0, hs_seen = 0, vld_cycles = 0;
  logic [7:0] mb [0:31];

  // Monitor: counts pulses and pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_format === 1'b1) fmt_seen++;
      if (err_overflow === 1'b1) ovf_seen++;
      if (awvalid === 1'b1) vld_cycles++;
      if (awvalid === 1'b1 && awready === 1'b1 && cke === 1'b1) begin
        hs_seen++;
        n_checks++;
        mon_act = '{id:awid, addr:awaddr, len:awlen, size:awsize, burst:awburst, lock:awlock,
                    cache:awcache, prot:awprot, region:awregion, qos:awqos, src:aw_src};
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL aw_unexpected: got beat %h, required no beat", mon_act);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL aw_beat: got %h, required %h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk_exp(input logic [15:0] id16, input logic [63:0] a, input logic [7:0] len,
                                  input logic [7:0] b12, input logic [7:0] b13, input logic [7:0] b14,
                                  input logic [7:0] b15, input logic [7:0] s);
    exp_t e;
    e.id = id16[IDW-1:0];  e.addr = a[AW-1:0];   e.len = len[LW-1:0];
    e.burst = b12[1:0];    e.lock = b12[2];      e.prot = b12[6:4];
    e.size = b13[2:0];     e.cache = b14[3:0];   e.region = b14[7:4];
    e.qos = b15[QW-1:0];   e.src = s;
    return e;
  endfunction

  task automatic build(input logic [15:0] id16, input logic [63:0] a, input logic [7:0] len,
                       input logic [7:0] b12, input logic [7:0] b13, input logic [7:0] b14,
                       input logic [7:0] b15);
    mb[0] = 8'h10; mb[1] = id16[7:0]; mb[2] = id16[15:8];
    for (int k = 0; k < 8; k++) mb[3+k] = a[8*k +: 8];
    mb[11] = len; mb[12] = b12; mb[13] = b13; mb[14] = b14; mb[15] = b15;
  endtask

  task automatic send(input int lo, input int hi, input bit use_first, input bit use_last,
                      input logic [7:0] s);
    for (int i = lo; i <= hi; i++) begin
      valid = 1'b1; data = mb[i]; src = s;
      first = use_first && (i == lo);
      last  = use_last && (i == hi);
      @(posedge clk); #1;
    end
    valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cke = 1'b1; valid = 1'b0; first = 1'b0; last = 1'b0;
    src = 8'h00; data = 8'h00; awready = 1'b0;
    idle(3);
    n_checks++;
    if ({awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
         aw_src, err_format, err_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got awvalid=%b addr=%h src=%h errs=%b%b, required all zero",
               awvalid, awaddr, aw_src, err_format, err_overflow);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    int hs0, v0;
    awready = 1'b1;
    hs0 = hs_seen; v0 = vld_cycles;
    build(16'h0025, 64'h0000_0000_1234_5678, 8'h0f, 8'h21, 8'h03, 8'h53, 8'h07);
    sb.push_back('{id:6'h25, addr:64'h1234_5678, len:8'd15, size:3'd3, burst:2'd1, lock:1'b0,
                   cache:4'd3, prot:3'd2, region:4'd5, qos:4'd7, src:8'h04});
    send(0, 15, 1'b1, 1'b1, 8'h04);
    n_checks++;
    if (awvalid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency: got awvalid=%b, required 1", awvalid);
    end
    idle(1);
    n_checks++;
    if (awvalid !== 1'b0 || hs_seen != hs0 + 1 || vld_cycles != v0 + 1) begin
      n_fail++;
      $display("FAIL basic_one_beat: got awvalid=%b hs=%0d cycles=%0d, required 0 1 1",
               awvalid, hs_seen - hs0, vld_cycles - v0);
    end
    // All-ones fields exercise truncation and reserved-bit masking.
    build(16'hffff, 64'hfedc_ba98_7654_3210, 8'h81, 8'hff, 8'hff, 8'hff, 8'hff);
    sb.push_back(mk_exp(16'hffff, 64'hfedc_ba98_7654_3210, 8'h81, 8'hff, 8'hff, 8'hff, 8'hff, 8'hc3));
    send(0, 15, 1'b1, 1'b1, 8'hc3);
    idle(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_stall;
    int hs0;
    awready = 1'b0;
    hs0 = hs_seen;
    build(16'h0025, 64'h0000_0000_1234_5678, 8'h0f, 8'h21, 8'h03, 8'h53, 8'h07);
    sb.push_back(mk_exp(16'h0025, 64'h1234_5678, 8'h0f, 8'h21, 8'h03, 8'h53, 8'h07, 8'h04));
    send(0, 15, 1'b1, 1'b1, 8'h04);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (awvalid !== 1'b1 || awaddr !== 64'h1234_5678 || awid !== 6'h25 || awlen !== 8'h0f) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b addr=%h id=%h len=%h, required 1 12345678 25 0f",
                 i, awvalid, awaddr, awid, awlen);
      end
      idle(1);
    end
    awready = 1'b1;
    idle(1);
    n_checks++;
    if (awvalid !== 1'b0 || hs_seen != hs0 + 1) begin
      n_fail++;
      $display("FAIL stall_release: got awvalid=%b hs=%0d, required 0 1", awvalid, hs_seen - hs0);
    end
  endtask

  task automatic test_overflow;
    int ovf0, hs0;
    awready = 1'b0;
    ovf0 = ovf_seen; hs0 = hs_seen;
    build(16'h0011, 64'h0000_0000_aaaa_0000, 8'h03, 8'h01, 8'h02, 8'h00, 8'h01);
    sb.push_back(mk_exp(16'h0011, 64'haaaa_0000, 8'h03, 8'h01, 8'h02, 8'h00, 8'h01, 8'h09));
    send(0, 15, 1'b1, 1'b1, 8'h09);
    build(16'h0022, 64'h0000_0000_bbbb_0000, 8'h07, 8'h01, 8'h02, 8'h00, 8'h02);
    send(0, 15, 1'b1, 1'b1, 8'h0a);
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_pulse: got %b, required 1", err_overflow);
    end
    idle(3);
    n_checks++;
    if (ovf_seen != ovf0 + 1 || awaddr !== 64'haaaa_0000 || aw_src !== 8'h09) begin
      n_fail++;
      $display("FAIL overflow_hold: got pulses=%0d addr=%h src=%h, required 1 aaaa0000 09",
               ovf_seen - ovf0, awaddr, aw_src);
    end
`ifdef JELLY2_NECOLINK_AW_RX_STATUS_EN
    n_checks++;
    if (ovf_count !== 16'd1) begin
      n_fail++; $display("FAIL overflow_count: got %0d, required 1", ovf_count);
    end
`endif
    awready = 1'b1;
    idle(2);
    n_checks++;
    if (hs_seen != hs0 + 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL overflow_drain: got hs=%0d pending=%0d, required 1 0", hs_seen - hs0, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int ovf0, hs0;
    awready = 1'b0;
    ovf0 = ovf_seen; hs0 = hs_seen;
    build(16'h0003, 64'h0000_0000_0000_1000, 8'h01, 8'h01, 8'h02, 8'h00, 8'h00);
    sb.push_back(mk_exp(16'h0003, 64'h1000, 8'h01, 8'h01, 8'h02, 8'h00, 8'h00, 8'h01));
    send(0, 15, 1'b1, 1'b1, 8'h01);
    build(16'h0004, 64'h0000_0000_0000_2000, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00);
    sb.push_back(mk_exp(16'h0004, 64'h2000, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00, 8'h02));
    send(0, 14, 1'b1, 1'b0, 8'h02);
    // Handshake of the held beat coincides with the last byte of the next message.
    valid = 1'b1; data = mb[15]; src = 8'h02; last = 1'b1; awready = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
    n_checks++;
    if (awvalid !== 1'b1 || awaddr !== 64'h2000 || ovf_seen != ovf0) begin
      n_fail++;
      $display("FAIL b2b_reload: got valid=%b addr=%h ovf=%0d, required 1 2000 0",
               awvalid, awaddr, ovf_seen - ovf0);
    end
    idle(2);
    n_checks++;
    if (hs_seen != hs0 + 2 || awvalid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got hs=%0d valid=%b pending=%0d, required 2 0 0",
               hs_seen - hs0, awvalid, sb.size());
    end
  endtask

  task automatic test_format;
    int fmt0, ovf0, v0;
    awready = 1'b1;
    fmt0 = fmt_seen; ovf0 = ovf_seen; v0 = vld_cycles;
    build(16'h0001, 64'h0, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00);
    send(0, 9, 1'b1, 1'b1, 8'h05);
    n_checks++;
    if (err_format !== 1'b1) begin
      n_fail++; $display("FAIL format_short_pulse: got %b, required 1", err_format);
    end
    mb[16] = 8'haa;
    send(0, 16, 1'b1, 1'b1, 8'h05);
    mb[0] = 8'h20;
    send(0, 15, 1'b1, 1'b1, 8'h05);
    idle(3);
    n_checks++;
    if (fmt_seen != fmt0 + 2 || vld_cycles != v0 || ovf_seen != ovf0) begin
      n_fail++;
      $display("FAIL format_errors: got fmt=%0d valid_cycles=%0d ovf=%0d, required 2 0 0",
               fmt_seen - fmt0, vld_cycles - v0, ovf_seen - ovf0);
    end
`ifdef JELLY2_NECOLINK_AW_RX_STATUS_EN
    n_checks++;
    if (fmt_count !== 16'd2) begin
      n_fail++; $display("FAIL format_count: got %0d, required 2", fmt_count);
    end
`endif
  endtask

  task automatic test_interrupt;
    int fmt0, hs0;
    awready = 1'b1;
    fmt0 = fmt_seen; hs0 = hs_seen;
    build(16'h0007, 64'h0000_0001_0000_0040, 8'h04, 8'h01, 8'h02, 8'h00, 8'h03);
    send(0, 5, 1'b1, 1'b0, 8'h06);
    sb.push_back(mk_exp(16'h0007, 64'h1_0000_0040, 8'h04, 8'h01, 8'h02, 8'h00, 8'h03, 8'h06));
    send(0, 15, 1'b1, 1'b1, 8'h06);
    idle(2);
    n_checks++;
    if (fmt_seen != fmt0 + 1 || hs_seen != hs0 + 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL interrupt: got fmt=%0d hs=%0d pending=%0d, required 1 1 0",
               fmt_seen - fmt0, hs_seen - hs0, sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int fmt0, ovf0, hs0, v0;
    awready = 1'b1;
    fmt0 = fmt_seen; ovf0 = ovf_seen; hs0 = hs_seen; v0 = vld_cycles;
    build(16'h0009, 64'h0000_0000_0000_3000, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00);
    send(0, 6, 1'b1, 1'b0, 8'h07);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(7, 15, 1'b0, 1'b1, 8'h07);
    idle(3);
    n_checks++;
    if (awvalid !== 1'b0 || vld_cycles != v0 || hs_seen != hs0 || fmt_seen != fmt0 ||
        ovf_seen != ovf0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b cycles=%0d fmt=%0d ovf=%0d, required 0 0 0 0",
               awvalid, vld_cycles - v0, fmt_seen - fmt0, ovf_seen - ovf0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_format();
    test_interrupt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
